// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and constants for the FP hazard controller
// Purpose: FP op codes, divide-sequencer state encoding and the FPR index type.
// Ports: none (package).
package fp_pkg;

  // 5-bit FP register index; f0 is a real register.
  typedef logic [4:0] fpr_t;

  localparam logic [2:0] FC_ADD  = 3'b000;
  localparam logic [2:0] FC_SUB  = 3'b001;
  localparam logic [2:0] FC_MUL  = 3'b010;
  localparam logic [2:0] FC_DIV  = 3'b100;
  localparam logic [2:0] FC_SQRT = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } div_state_t;

  // div and sqrt share op-code bit 2; both are iterative ops.
  function automatic logic is_iter(input logic [2:0] fc);
    return (fc & FC_DIV) == FC_DIV;
  endfunction

endpackage

// File: rtl/fp_hazard_ctrl_if.sv
// rtl/fp_hazard_ctrl_if.sv - ID/EX/MEM hazard inputs and stall/forward outputs
// Purpose: bundles everything the hazard controller sees from the pipeline and
//          drives back to the IU and FPR read muxes.
// Ports: slave  = controller side (consumes id_/e_/m_/ext_stl, drives e*n/e*w,
//                 fwd*, stl*); master = pipeline side (the reverse).
interface fp_hazard_ctrl_if;
  import fp_pkg::*;

  logic       id_fop;
  logic [2:0] id_fc;
  fpr_t       id_fs;
  fpr_t       id_ft;
  fpr_t       id_fd;
  logic       id_swc1;
  logic       e_lwc1;
  fpr_t       e_rt;
  logic       m_lwc1;
  fpr_t       m_rt;
  logic       ext_stl;

  fpr_t       e1n;
  fpr_t       e2n;
  fpr_t       e3n;
  logic       e1w;
  logic       e2w;
  logic       e3w;
  logic       fwdla;
  logic       fwdlb;
  logic       fwdfa;
  logic       fwdfb;
  logic       stl_fp;
  logic       stl_lwc1;
  logic       stl_swc1;
  logic       stl_div;
  logic       stl;

  modport slave (
    input  id_fop, id_fc, id_fs, id_ft, id_fd, id_swc1,
    input  e_lwc1, e_rt, m_lwc1, m_rt, ext_stl,
    output e1n, e2n, e3n, e1w, e2w, e3w,
    output fwdla, fwdlb, fwdfa, fwdfb,
    output stl_fp, stl_lwc1, stl_swc1, stl_div, stl
  );

  modport master (
    output id_fop, id_fc, id_fs, id_ft, id_fd, id_swc1,
    output e_lwc1, e_rt, m_lwc1, m_rt, ext_stl,
    input  e1n, e2n, e3n, e1w, e2w, e3w,
    input  fwdla, fwdlb, fwdfa, fwdfb,
    input  stl_fp, stl_lwc1, stl_swc1, stl_div, stl
  );

endinterface

// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - iterative-issue sequencer holding fdiv/fsqrt in ID
// Purpose: counts DIV_CYCLES-1 stall cycles for an iterative op, then lets it
//          issue in the first cycle no other stall cause is active.
// Ports: clk, clrn (async active-low); isdiv (ID holds div/sqrt); stl_other
//        (every stall cause except this one); stl_div (stall request);
//        busy (sequencer is counting or waiting to issue).
module fp_div_seq
  import fp_pkg::*;
#(
  parameter int DIV_CYCLES = 4,
  parameter int CNT_W      = 3
) (
  input  logic clk,
  input  logic clrn,
  input  logic isdiv,
  input  logic stl_other,
  output logic stl_div,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stl_div  = 1'b0;
    case (state)
      IDLE: begin
        // Start only once nothing else is stalling ID, so the count covers
        // cycles the op would otherwise have been free to issue.
        if (isdiv && !stl_other) begin
          state_nx = BUSY;
          cnt_nx   = CNT_LOAD;
          stl_div  = 1'b1;
        end
      end
      BUSY: begin
        if (cnt > CNT_ONE) begin
          stl_div = 1'b1;
          cnt_nx  = cnt - CNT_ONE;
        end else if (!stl_other) begin
          // Final cycle: the op leaves ID this edge.
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
    endcase
    // The op still sitting in ID during reset must not look like a stall;
    // it restarts its full count once reset is released.
    if (!clrn) stl_div = 1'b0;
  end

  assign busy = (state == BUSY);

endmodule

// File: rtl/fp_hazard_ctrl.sv
// rtl/fp_hazard_ctrl.sv - FP data-hazard stall and forwarding controller
// Purpose: shadows the 3-stage FPU destination pipe and compares the ID FP
//          instruction against it and against in-flight lwc1 loads.
// Ports: clk, clrn (async active-low); hz (slave) carries the ID operands,
//        EX/MEM lwc1 info and ext_stl in, and the shadow pipe, forward
//        selects and stall causes out.
module fp_hazard_ctrl
  import fp_pkg::*;
#(
  parameter int DIV_CYCLES = 4,
  parameter int CNT_W      = 3
) (
  input  logic                clk,
  input  logic                clrn,
  fp_hazard_ctrl_if.slave     hz
);

  fpr_t e1n_q, e2n_q, e3n_q;
  logic e1w_q, e2w_q, e3w_q;

  logic usea, useb;
  logic isdiv;
  logic hit_e1_ab, hit_e2_ab, hit_e1_b, hit_e2_b;
  logic stl_fp, stl_lwc1, stl_swc1, stl_div, stl_other, stl;
  logic fwdla, fwdlb;
  logic div_busy;

  assign usea  = hz.id_fop;
  assign useb  = hz.id_fop | hz.id_swc1;
  assign isdiv = hz.id_fop & is_iter(hz.id_fc);

  // Results in e1/e2 are not yet available for forwarding; only e3 is.
  assign hit_e1_ab = e1w_q & ((e1n_q == hz.id_fs) | (e1n_q == hz.id_ft));
  assign hit_e2_ab = e2w_q & ((e2n_q == hz.id_fs) | (e2n_q == hz.id_ft));
  assign hit_e1_b  = e1w_q & (e1n_q == hz.id_ft);
  assign hit_e2_b  = e2w_q & (e2n_q == hz.id_ft);

  assign stl_fp   = hz.id_fop  & (hit_e1_ab | hit_e2_ab);
  assign stl_swc1 = hz.id_swc1 & (hit_e1_b  | hit_e2_b);
  assign stl_lwc1 = hz.e_lwc1 & ((usea & (hz.e_rt == hz.id_fs)) |
                                 (useb & (hz.e_rt == hz.id_ft)));

  // stl_div consumes stl_other, never stl, so there is no loop through stl.
  assign stl_other = stl_fp | stl_lwc1 | stl_swc1 | hz.ext_stl;
  assign stl       = stl_other | stl_div;

  // The MEM lwc1 is younger than the e3 result, so it takes priority.
  assign fwdla = usea & hz.m_lwc1 & (hz.m_rt == hz.id_fs);
  assign fwdlb = useb & hz.m_lwc1 & (hz.m_rt == hz.id_ft);

  fp_div_seq #(
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_div_seq (
    .clk       (clk),
    .clrn      (clrn),
    .isdiv     (isdiv),
    .stl_other (stl_other),
    .stl_div   (stl_div),
    .busy      (div_busy)
  );

  // The FP pipe never stalls; a stalled ID op enters e1 as a bubble.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      e1n_q <= '0;
      e2n_q <= '0;
      e3n_q <= '0;
      e1w_q <= 1'b0;
      e2w_q <= 1'b0;
      e3w_q <= 1'b0;
    end else begin
      e3n_q <= e2n_q;
      e3w_q <= e2w_q;
      e2n_q <= e1n_q;
      e2w_q <= e1w_q;
      e1n_q <= hz.id_fd;
      e1w_q <= hz.id_fop & ~stl;
    end
  end

  // The sequencer relies on the IU holding the iterative op in ID while stalled.
  a_div_held: assert property (@(posedge clk) disable iff (!clrn)
                               (div_busy && stl) |=> isdiv);

  assign hz.e1n      = e1n_q;
  assign hz.e2n      = e2n_q;
  assign hz.e3n      = e3n_q;
  assign hz.e1w      = e1w_q;
  assign hz.e2w      = e2w_q;
  assign hz.e3w      = e3w_q;
  assign hz.fwdla    = fwdla;
  assign hz.fwdlb    = fwdlb;
  assign hz.fwdfa    = usea & e3w_q & (e3n_q == hz.id_fs) & ~fwdla;
  assign hz.fwdfb    = useb & e3w_q & (e3n_q == hz.id_ft) & ~fwdlb;
  assign hz.stl_fp   = stl_fp;
  assign hz.stl_lwc1 = stl_lwc1;
  assign hz.stl_swc1 = stl_swc1;
  assign hz.stl_div  = stl_div;
  assign hz.stl      = stl;

endmodule

// File: tb/tb_fp_hazard_ctrl.sv
// tb/tb_fp_hazard_ctrl.sv - scoreboard bench for fp_hazard_ctrl
module tb_fp_hazard_ctrl;
  import fp_pkg::*;

  localparam int DIV_CYCLES = 4;

  typedef struct packed {
    logic       fop;
    logic [2:0] fc;
    logic [4:0] fs, ft, fd;
    logic       swc1;
    logic       e_lwc1;
    logic [4:0] e_rt;
    logic       m_lwc1;
    logic [4:0] m_rt;
    logic       ext;
  } stim_t;

  typedef struct packed {
    logic [14:0] shadow;  // {e1n,e2n,e3n}
    logic [2:0]  wen;     // {e1w,e2w,e3w}
    logic [3:0]  fwd;     // {fwdla,fwdlb,fwdfa,fwdfb}
    logic [4:0]  stall;   // {stl_fp,stl_lwc1,stl_swc1,stl_div,stl}
  } exp_t;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  fp_hazard_ctrl_if hz();

  fp_hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(3)) dut (
    .clk  (clk),
    .clrn (clrn),
    .hz   (hz)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  // Reference model: the last three issued destinations, newest first, plus
  // how many divide stall cycles the op in ID has served.
  logic [4:0] pn[3];
  logic       pw[3];
  bit         div_active;
  int         div_served;
  bit         prev_stl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      pn[k] = '0;
      pw[k] = 1'b0;
    end
    div_active = 0;
    div_served = 0;
    prev_stl   = 0;
  endtask

  task automatic model_step(input stim_t s, output exp_t e);
    bit usea, useb, sfp, ssw, slw, fla, flb, ffa, ffb, other, sdiv, isdiv, stl;
    usea = s.fop;
    useb = s.fop | s.swc1;
    sfp  = 0;
    ssw  = 0;
    for (int k = 0; k < 2; k++) begin
      if (pw[k]) begin
        if (pn[k] == s.fs || pn[k] == s.ft) sfp |= s.fop;
        if (pn[k] == s.ft) ssw |= s.swc1;
      end
    end
    slw = s.e_lwc1 && ((usea && s.e_rt == s.fs) || (useb && s.e_rt == s.ft));
    fla = usea && s.m_lwc1 && s.m_rt == s.fs;
    flb = useb && s.m_lwc1 && s.m_rt == s.ft;
    ffa = usea && pw[2] && pn[2] == s.fs && !fla;
    ffb = useb && pw[2] && pn[2] == s.ft && !flb;
    other = sfp | slw | ssw | s.ext;
    isdiv = s.fop && (s.fc >= 3'd4);
    sdiv  = 0;
    if (!div_active) begin
      if (isdiv && !other) begin
        sdiv = 1; div_active = 1; div_served = 1;
      end
    end else if (div_served < DIV_CYCLES - 1) begin
      sdiv = 1; div_served++;
    end else if (!other) begin
      div_active = 0;
    end
    stl = other | sdiv;
    e.shadow = {pn[0], pn[1], pn[2]};
    e.wen    = {pw[0], pw[1], pw[2]};
    e.fwd    = {fla, flb, ffa, ffb};
    e.stall  = {sfp, slw, ssw, sdiv, stl};
    pn[2] = pn[1]; pw[2] = pw[1];
    pn[1] = pn[0]; pw[1] = pw[0];
    pn[0] = s.fd;  pw[0] = s.fop & ~stl;
    prev_stl = stl;
  endtask

  task automatic drive(input stim_t s);
    hz.id_fop  = s.fop;
    hz.id_fc   = s.fc;
    hz.id_fs   = s.fs;
    hz.id_ft   = s.ft;
    hz.id_fd   = s.fd;
    hz.id_swc1 = s.swc1;
    hz.e_lwc1  = s.e_lwc1;
    hz.e_rt    = s.e_rt;
    hz.m_lwc1  = s.m_lwc1;
    hz.m_rt    = s.m_rt;
    hz.ext_stl = s.ext;
  endtask

  task automatic step(input stim_t s, input bit release_rst);
    exp_t e;
    @(posedge clk);
    #1;
    if (release_rst) clrn = 1'b1;
    drive(s);
    model_step(s, e);
    sb_q.push_back(e);
  endtask

  // Keep presenting the same ID op until the model says it issued.
  task automatic issue(input stim_t s);
    step(s, 0);
    for (int i = 0; i < 20 && prev_stl; i++) step(s, 0);
  endtask

  function automatic stim_t fop(input logic [2:0] fc, input int fd, input int fs, input int ft);
    stim_t s;
    s = '0;
    s.fop = 1'b1; s.fc = fc;
    s.fd = 5'(fd); s.fs = 5'(fs); s.ft = 5'(ft);
    return s;
  endfunction

  // Monitor: every cycle the outputs are valid; compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("shadow_n", 32'({hz.e1n, hz.e2n, hz.e3n}), 32'(e.shadow));
        chk("shadow_w", 32'({hz.e1w, hz.e2w, hz.e3w}), 32'(e.wen));
        chk("forward", 32'({hz.fwdla, hz.fwdlb, hz.fwdfa, hz.fwdfb}), 32'(e.fwd));
        chk("stall", 32'({hz.stl_fp, hz.stl_lwc1, hz.stl_swc1, hz.stl_div, hz.stl}),
            32'(e.stall));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s, nop;
    nop = '0;
    model_reset();

    // Reset with a divide sitting in ID: nothing may stall or be valid.
    clrn = 1'b0;
    drive(fop(FC_DIV, 10, 11, 12));
    #1;
    chk("rst_ew", 32'({hz.e1w, hz.e2w, hz.e3w}), 32'd0);
    chk("rst_stl_div", 32'(hz.stl_div), 32'd0);
    chk("rst_stl", 32'(hz.stl), 32'd0);
    chk("rst_en", 32'({hz.e1n, hz.e2n, hz.e3n}), 32'd0);
    step(nop, 1);
    step(nop, 0);

    // Back-to-back dependency through e1/e2, then e3 forwarding.
    issue(fop(FC_ADD, 3, 1, 2));
    issue(fop(FC_MUL, 4, 3, 5));
    repeat (3) step(nop, 0);

    // lwc1 load-use, then MEM forwarding.
    s = fop(FC_ADD, 8, 7, 6);
    s.e_lwc1 = 1'b1; s.e_rt = 5'd7;
    step(s, 0);
    s.e_lwc1 = 1'b0; s.m_lwc1 = 1'b1; s.m_rt = 5'd7;
    step(s, 0);
    repeat (3) step(nop, 0);

    // Forward priority: MEM lwc1 beats e3 result for swc1.
    issue(fop(FC_ADD, 9, 1, 2));
    step(nop, 0);
    step(nop, 0);
    s = '0;
    s.swc1 = 1'b1; s.ft = 5'd9; s.m_lwc1 = 1'b1; s.m_rt = 5'd9;
    step(s, 0);
    repeat (3) step(nop, 0);

    // Plain divide and sqrt.
    issue(fop(FC_DIV, 10, 11, 12));
    repeat (3) step(nop, 0);
    issue(fop(FC_SQRT, 13, 14, 14));
    repeat (3) step(nop, 0);

    // Divide overlapped with ext_stl at the final count.
    s = fop(FC_DIV, 15, 16, 17);
    for (int i = 0; i < DIV_CYCLES - 1; i++) step(s, 0);
    s.ext = 1'b1;
    step(s, 0);
    step(s, 0);
    s.ext = 1'b0;
    step(s, 0);
    repeat (3) step(nop, 0);

    // Async reset mid-divide with the shadow pipe populated.
    issue(fop(FC_ADD, 1, 2, 3));
    issue(fop(FC_ADD, 4, 5, 6));
    issue(fop(FC_ADD, 7, 8, 9));
    s = fop(FC_DIV, 10, 11, 12);
    step(s, 0);
    step(s, 0);
    @(negedge clk);
    #2;
    clrn = 1'b0;
    #1;
    chk("amid_ew", 32'({hz.e1w, hz.e2w, hz.e3w}), 32'd0);
    chk("amid_stl_div", 32'(hz.stl_div), 32'd0);
    chk("amid_stl", 32'(hz.stl), 32'd0);
    model_reset();
    step(s, 1);
    for (int i = 0; i < 20 && prev_stl; i++) step(s, 0);

    // Random traffic; ID advances only when the model says it was not stalled.
    s = nop;
    for (int n = 0; n < 1500; n++) begin
      if (!prev_stl) begin
        s.fop  = ($urandom_range(0, 9) < 6);
        s.swc1 = !s.fop && ($urandom_range(0, 3) == 0);
        s.fc   = 3'($urandom_range(0, 5));
        s.fs   = 5'($urandom_range(0, 7));
        s.ft   = 5'($urandom_range(0, 7));
        s.fd   = 5'($urandom_range(0, 7));
      end
      s.e_lwc1 = ($urandom_range(0, 9) < 3);
      s.e_rt   = 5'($urandom_range(0, 7));
      s.m_lwc1 = ($urandom_range(0, 9) < 3);
      s.m_rt   = 5'($urandom_range(0, 7));
      s.ext    = ($urandom_range(0, 9) == 0);
      step(s, 0);
    end

    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
